// File: rtl/pll_lock_monitor.sv
// rtl/pll_lock_monitor.sv - qualifies PLL lock and releases sys_rst_n; define PLL_LOCK_MON_FREQ_CHECK_EN to build the ref_clk frequency check
module pll_lock_monitor #(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 1024,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int REF_EDGES       = 256,
  parameter int FREQ_NOM        = 1360,
  parameter int FREQ_TOL        = 8
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        pll_lock,
  input  logic        ref_clk,
  output logic        sys_rst_n,
  output logic        ready,
  output logic [7:0]  lock_loss_cnt,
  output logic [15:0] freq_cnt,
  output logic        freq_err
);

  typedef enum logic [2:0] {WAIT_LOCK, STABLE, FREQ, HOLD, RUN} state_t;

  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD_CYCLES - 1);

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;
  logic [15:0]            cnt, cnt_n;
  logic [7:0]             loss_n;

  assign lock_s = lock_sync[SYNC_STAGES-1];

`ifdef PLL_LOCK_MON_FREQ_CHECK_EN
  localparam logic [15:0]        EDGE_LAST = 16'(REF_EDGES - 1);
  localparam logic signed [16:0] NOM_S     = 17'(FREQ_NOM);
  localparam logic signed [16:0] TOL_S     = 17'(FREQ_TOL);

  logic [SYNC_STAGES-1:0] ref_sync;
  logic                   ref_s, ref_s_d, ref_rise;
  logic [15:0]            edge_cnt, edge_n;
  logic                   win_act, win_n;
  logic [15:0]            fcnt_n, meas;
  logic                   ferr_n, within;
  logic signed [16:0]     diff;

  assign ref_s    = ref_sync[SYNC_STAGES-1];
  assign ref_rise = ref_s & ~ref_s_d;
  // cnt is below 16'hFFFF whenever meas is used, so cnt+1 never wraps
  assign meas     = cnt + 16'd1;
  assign diff     = $signed({1'b0, meas}) - NOM_S;
  assign within   = (diff <= TOL_S) && (diff >= -TOL_S);
`else
  logic unused_ref;
  assign unused_ref = ref_clk;
  assign freq_cnt   = 16'd0;
  assign freq_err   = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    loss_n  = lock_loss_cnt;
`ifdef PLL_LOCK_MON_FREQ_CHECK_EN
    edge_n  = edge_cnt;
    win_n   = win_act;
    fcnt_n  = freq_cnt;
    ferr_n  = freq_err;
`endif
    if (state != WAIT_LOCK && !lock_s) begin
      state_n = WAIT_LOCK;
      cnt_n   = 16'd0;
`ifdef PLL_LOCK_MON_FREQ_CHECK_EN
      edge_n  = 16'd0;
      win_n   = 1'b0;
`endif
      if (state == RUN && lock_loss_cnt != 8'hFF)
        loss_n = lock_loss_cnt + 8'd1;
    end else begin
      case (state)
        WAIT_LOCK: if (lock_s) begin
          state_n = STABLE;
          cnt_n   = 16'd0;
        end
        STABLE: if (cnt == STABLE_LAST) begin
          cnt_n   = 16'd0;
`ifdef PLL_LOCK_MON_FREQ_CHECK_EN
          state_n = FREQ;
          edge_n  = 16'd0;
          win_n   = 1'b0;
`else
          state_n = HOLD;
`endif
        end else begin
          cnt_n = cnt + 16'd1;
        end
`ifdef PLL_LOCK_MON_FREQ_CHECK_EN
        // cnt runs from FREQ entry so a dead ref_clk still times out
        FREQ: if (cnt == 16'hFFFF) begin
          fcnt_n = 16'hFFFF;
          ferr_n = 1'b1;
          cnt_n  = 16'd0;
          edge_n = 16'd0;
          win_n  = 1'b0;
        end else if (ref_rise) begin
          if (!win_act) begin
            win_n  = 1'b1;
            cnt_n  = 16'd0;
            edge_n = 16'd0;
          end else if (edge_cnt == EDGE_LAST) begin
            fcnt_n = meas;
            cnt_n  = 16'd0;
            edge_n = 16'd0;
            if (within) begin
              ferr_n  = 1'b0;
              win_n   = 1'b0;
              state_n = HOLD;
            end else begin
              ferr_n = 1'b1;
            end
          end else begin
            edge_n = edge_cnt + 16'd1;
            cnt_n  = cnt + 16'd1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
`endif
        HOLD: if (cnt == HOLD_LAST) begin
          state_n = RUN;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
        RUN:     ;
        default: state_n = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state         <= WAIT_LOCK;
      lock_sync     <= '0;
      cnt           <= 16'd0;
      lock_loss_cnt <= 8'd0;
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
`ifdef PLL_LOCK_MON_FREQ_CHECK_EN
      ref_sync      <= '0;
      ref_s_d       <= 1'b0;
      edge_cnt      <= 16'd0;
      win_act       <= 1'b0;
      freq_cnt      <= 16'd0;
      freq_err      <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      lock_sync     <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
      cnt           <= cnt_n;
      lock_loss_cnt <= loss_n;
      sys_rst_n     <= (state_n == RUN);
      ready         <= (state_n == RUN);
`ifdef PLL_LOCK_MON_FREQ_CHECK_EN
      ref_sync      <= {ref_sync[SYNC_STAGES-2:0], ref_clk};
      ref_s_d       <= ref_s;
      edge_cnt      <= edge_n;
      win_act       <= win_n;
      freq_cnt      <= fcnt_n;
      freq_err      <= ferr_n;
`endif
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb/tb_pll_lock_monitor.sv - directed table-driven bench for pll_lock_monitor
module tb_pll_lock_monitor;
  localparam int SYNC = 2, STAB = 16, HOLDC = 4, REFE = 16, NOM = 256, TOL = 2;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_lock = 1'b0;
  logic        ref_clk = 1'b0;
  logic        sys_rst_n, ready, freq_err;
  logic [7:0]  lock_loss_cnt;
  logic [15:0] freq_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int ref_half = 8;
  logic ref_en = 1'b0;

  pll_lock_monitor #(
    .SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .RST_HOLD_CYCLES(HOLDC),
    .REF_EDGES(REFE), .FREQ_NOM(NOM), .FREQ_TOL(TOL)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .pll_lock(pll_lock), .ref_clk(ref_clk),
    .sys_rst_n(sys_rst_n), .ready(ready), .lock_loss_cnt(lock_loss_cnt),
    .freq_cnt(freq_cnt), .freq_err(freq_err)
  );

  always #5 sys_clk = ~sys_clk;

  always begin
    for (int k = 0; k < ref_half; k++) @(posedge sys_clk);
    #1;
    if (ref_en) ref_clk = ~ref_clk;
    else        ref_clk = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  typedef struct packed {
    logic        rst;
    logic        lock;
    logic [15:0] cycles;
    logic        srst;
    logic        rdy;
    logic [7:0]  loss;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic l, input int c, input logic s, input logic y, input logic [7:0] n);
    vec_t v;
    v.rst = r; v.lock = l; v.cycles = 16'(c); v.srst = s; v.rdy = y; v.loss = n;
    tbl.push_back(v);
  endtask

`ifdef PLL_LOCK_MON_FREQ_CHECK_EN
  task automatic restart();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    pll_lock = 1'b1;
  endtask
`endif

  initial begin
`ifndef PLL_LOCK_MON_FREQ_CHECK_EN
    // reset, power-up latency, 5-cycle drop in RUN, rst_n in RUN, 1-cycle glitch at STABLE count 10
    add(0, 1, 2,  0, 0, 0);
    add(1, 1, 22, 0, 0, 0);
    add(1, 1, 1,  1, 1, 0);
    add(1, 1, 4,  1, 1, 0);
    add(1, 0, 2,  1, 1, 0);
    add(1, 0, 1,  0, 0, 1);
    add(1, 0, 2,  0, 0, 1);
    add(1, 1, 22, 0, 0, 1);
    add(1, 1, 1,  1, 1, 1);
    add(0, 1, 1,  0, 0, 0);
    add(1, 1, 22, 0, 0, 0);
    add(1, 1, 1,  1, 1, 0);
    add(0, 1, 1,  0, 0, 0);
    add(1, 1, 13, 0, 0, 0);
    add(1, 0, 1,  0, 0, 0);
    add(1, 1, 22, 0, 0, 0);
    add(1, 1, 1,  1, 1, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      rst_n    = tbl[r].rst;
      pll_lock = tbl[r].lock;
      for (int c = 0; c < int'(tbl[r].cycles); c++) begin
        tick();
        check($sformatf("row%0d.c%0d sys_rst_n", r, c), 32'(sys_rst_n), 32'(tbl[r].srst));
        check($sformatf("row%0d.c%0d ready", r, c), 32'(ready), 32'(tbl[r].rdy));
        check($sformatf("row%0d.c%0d lock_loss_cnt", r, c), 32'(lock_loss_cnt), 32'(tbl[r].loss));
        check($sformatf("row%0d.c%0d freq_cnt", r, c), 32'(freq_cnt), 32'd0);
        check($sformatf("row%0d.c%0d freq_err", r, c), 32'(freq_err), 32'd0);
      end
    end

    // 300 lock drops from RUN: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      tick(); tick(); tick();
      check($sformatf("drop%0d sys_rst_n low", i), 32'(sys_rst_n), 32'd0);
      if (i == 0)   check("loss after first drop", 32'(lock_loss_cnt), 32'd1);
      if (i == 254) check("loss at 255th drop", 32'(lock_loss_cnt), 32'd255);
      tick(); tick();
      pll_lock = 1'b1;
      for (int c = 0; c < 23; c++) tick();
      check($sformatf("drop%0d requalified", i), 32'(ready), 32'd1);
    end
    check("loss saturated", 32'(lock_loss_cnt), 32'd255);
`else
    begin : freq_suite
      int t;
      logic seen;
      ref_en = 1'b1;
      ref_half = 8;
      restart();
      check("freq reset freq_cnt", 32'(freq_cnt), 32'd0);
      pll_lock = 1'b1;
      t = 0;
      while (!ready && t < 3000) begin tick(); t++; end
      check("period16 run reached", 32'(ready), 32'd1);
      check("period16 freq_cnt", 32'(freq_cnt), 32'd256);
      check("period16 freq_err", 32'(freq_err), 32'd0);
      check("period16 sys_rst_n", 32'(sys_rst_n), 32'd1);

      ref_half = 9;
      restart();
      t = 0;
      while (!freq_err && t < 3000) begin tick(); t++; end
      check("period18 freq_err", 32'(freq_err), 32'd1);
      check("period18 freq_cnt", 32'(freq_cnt), 32'd288);
      seen = 1'b0;
      for (int c = 0; c < 1500; c++) begin tick(); if (ready) seen = 1'b1; end
      check("period18 never ready", 32'(seen), 32'd0);
      check("period18 sys_rst_n", 32'(sys_rst_n), 32'd0);
      ref_half = 8;
      t = 0;
      while (!ready && t < 3000) begin tick(); t++; end
      check("restored run reached", 32'(ready), 32'd1);
      check("restored freq_cnt", 32'(freq_cnt), 32'd256);
      check("restored freq_err", 32'(freq_err), 32'd0);

      ref_en = 1'b0;
      for (int c = 0; c < 20; c++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      pll_lock = 1'b1;
      t = 0;
      while (!freq_err && t < 70000) begin tick(); t++; end
      check("timeout freq_err", 32'(freq_err), 32'd1);
      check("timeout cycle", 32'(t), 32'd65555);
      check("timeout freq_cnt", 32'(freq_cnt), 32'hFFFF);
      check("timeout sys_rst_n", 32'(sys_rst_n), 32'd0);
      check("timeout ready", 32'(ready), 32'd0);
      check("timeout loss", 32'(lock_loss_cnt), 32'd0);
    end
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
